// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a big-endian byte stream
// (16-bit word count, then words) and writes it into instruction memory.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERROR
    } stateT;

    stateT       state, nextState;
    logic [15:0] count;
    logic [15:0] wordIdx;
    logic [1:0]  byteIdx;
    logic [23:0] buffer;
    logic        xfer;
    logic [15:0] fullCount;
    logic        countBad;
    logic        lastWord;

    assign xfer      = byte_valid && byte_ready;
    assign fullCount = {count[15:8], byte_data};
    assign countBad  = (fullCount == '0) || (32'(fullCount) > MAX_WORDS);
    assign lastWord  = (wordIdx + 16'd1) == count;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE, ERROR: if (start) nextState = CNT_HI;
            CNT_HI:            if (xfer) nextState = CNT_LO;
            CNT_LO:            if (xfer) nextState = countBad ? ERROR : DATA;
            DATA:              if (xfer && byteIdx == 2'd3) nextState = WRITE;
            WRITE:             nextState = lastWord ? DONE : DATA;
            default:           nextState = IDLE;
        endcase
    end

    // Outputs are registered from nextState so the write strobe lands in the
    // cycle right after the 4th data byte is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            count      <= '0;
            wordIdx    <= '0;
            byteIdx    <= '0;
            buffer     <= '0;
        end else begin
            byte_ready <= (nextState == CNT_HI) || (nextState == CNT_LO) || (nextState == DATA);
            imem_we    <= (nextState == WRITE);
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        wordIdx  <= '0;
                    end
                end
                CNT_HI: if (xfer) count[15:8] <= byte_data;
                CNT_LO: begin
                    if (xfer) begin
                        count[7:0] <= byte_data;
                        byteIdx    <= '0;
                        if (countBad) error <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        buffer  <= {buffer[15:0], byte_data};
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            imem_addr  <= BASE_ADDR + {14'b0, wordIdx, 2'b00};
                            imem_wdata <= {buffer, byte_data};
                        end
                    end
                end
                WRITE: begin
                    if (lastWord) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        wordIdx <= wordIdx + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
